fakeram45_64x96_req_ctrl: RTL and testbench
===========================================

// Module: fakeram45_64x96_req_ctrl
// PURPOSE
//  Initiator for the 64x96 single-port fakeram45 macro port: ce/we/addr/wd/w_mask out, rd_out back one cycle later.
//  - Converts a valid/ready request stream into macro cycles.
//  - Returns read data on a valid/ready response stream with backpressure.
//  - Zero-initialises the whole array after reset, before requests are accepted.
// PARAMETERS
//  BITS        96  data/mask width
//  WORD_DEPTH  64  number of words
//  ADDR_WIDTH  6   address width, clog2(WORD_DEPTH)
//  RSP_DEPTH   2   response FIFO entries, >=1
// PORTS
//  clk              in   1           sole clock
//  rst_n            in   1           asynchronous, active-low reset
//  init_done_out    out  1           1 once zero-init is complete
//  req_valid_in     in   1           request valid
//  req_ready_out    out  1           request ready
//  req_we_in        in   1           1=write, 0=read
//  req_addr_in      in   ADDR_WIDTH  word address
//  req_wdata_in     in   BITS        write data
//  req_wmask_in     in   BITS        per-bit write enable
//  rsp_valid_out    out  1           read data valid
//  rsp_ready_in     in   1           consumer ready
//  rsp_data_out     out  BITS        read data
//  sram_ce_out      out  1           macro ce_in
//  sram_we_out      out  1           macro we_in
//  sram_addr_out    out  ADDR_WIDTH  macro addr_in
//  sram_wd_out      out  BITS        macro wd_in
//  sram_w_mask_out  out  BITS        macro w_mask_in
//  sram_rd_in       in   BITS        macro rd_out
// BEHAVIOUR
//  Reset values: init_done_out=0, req_ready_out=0, rsp_valid_out=0, sram_ce_out=0.
//  Reset internal state: FSM=INIT, init counter=0, FIFO empty, rd_pending=0.
//  FSM INIT: one write per cycle.
//  - sram_ce=1, we=1, addr=counter, wd=0, w_mask=all ones.
//  - Counter increments each cycle; after addr WORD_DEPTH-1 -> RUN.
//  - INIT lasts exactly WORD_DEPTH cycles.
//  FSM RUN: init_done_out=1. RUN is terminal until reset.
//  Credit rule: req_ready = (fifo_count + rd_pending) < RSP_DEPTH, or a FIFO pop occurs this cycle.
//  - Applies to reads and writes alike; ready never depends on req_we_in.
//  Accept = req_valid & req_ready.
//  - Macro outputs are combinational from the request that cycle: ce=accept, we=accept&req_we.
//  - addr/wd/w_mask are forced to 0 when ce=0, so no X ever reaches the macro.
//  Accepted read sets rd_pending for the next cycle.
//  - In that cycle sram_rd_in is pushed into the FIFO.
//  - sram_rd_in is ignored whenever rd_pending=0 (macro drives X when ce=0).
//  Writes produce no response. Write at A then read at A next cycle returns the new data.
//  FIFO: pop when rsp_valid & rsp_ready. Simultaneous push and pop when full is legal; the count is unchanged.
//  Credit accounting guarantees no push into a full FIFO; the bench asserts this.
//  Reset mid-operation: pending read and FIFO contents are discarded; FSM restarts INIT at addr 0.
//  Read latency: accept at cycle N -> rsp_valid at N+2 (no bypass).
// CONFIGURATION
//  FAKERAM_REQ_CTRL_RSP_BYPASS_EN defined:
//  - When the FIFO is empty and rd_pending=1, rsp_valid=1 and rsp_data=sram_rd_in combinationally at N+1.
//  - If rsp_ready=1 the word is consumed with no push; otherwise it is pushed.
//  Undefined: all read data passes through the FIFO; latency N+2; no comb path from sram_rd_in.
// STRUCTURE
//  Package fakeram_req_ctrl_pkg:
//  - state_e {INIT, RUN}.
//  - Default BITS/WORD_DEPTH/ADDR_WIDTH/RSP_DEPTH localparams.
//  Sub-module fakeram_rsp_fifo: RSP_DEPTH x BITS synchronous FIFO.
//  - Async active-low reset; push/pop/full/empty/count.
// TESTING
//  1 Release reset -> exactly 64 write cycles to addr 0..63, mask all ones, wd 0; init_done=1 at cycle 64; any read afterwards returns 0.
//  2 Write addr 5 data 0xA5.., full mask; read addr 5 next cycle -> rsp_data 0xA5.. at N+2 (N+1 with bypass).
//  3 Mem[9]=all ones; write 0 with mask 0x00..FF -> read returns 0xFF..FF00.
//  4 rsp_ready=0, issue 4 back-to-back reads -> exactly RSP_DEPTH accepted; ready drops; release -> data in order, no loss.
//  5 Steady reads with rsp_ready=1 -> one accept per cycle; no ce without accept; no X on macro inputs while ce=1.
//  6 Assert rst_n at init addr 30, and again with 1 read pending -> FIFO empty, no rsp_valid, init restarts at addr 0.

Source files
------------

// File: rtl/fakeram_req_ctrl_pkg.sv
// Shared types and default geometry for the fakeram45 64x96 request controller.
package fakeram_req_ctrl_pkg;

    localparam int unsigned DefBits      = 96;
    localparam int unsigned DefWordDepth = 64;
    localparam int unsigned DefAddrWidth = 6;
    localparam int unsigned DefRspDepth  = 2;

    typedef enum logic [0:0] {
        INIT,
        RUN
    } state_e;

    // Width needed to hold a count in 0..depth inclusive.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fakeram_rsp_fifo.sv
// Synchronous response FIFO; a push into a full FIFO is only taken together with a pop.
module fakeram_rsp_fifo
    import fakeram_req_ctrl_pkg::*;
#(
    parameter int unsigned Width = DefBits,
    parameter int unsigned Depth = DefRspDepth,
    localparam int unsigned CntW = cnt_width(Depth)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             pop_i,
    output logic [Width-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CntW-1:0]  count_o
);

    localparam int unsigned     PtrW    = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == FullCnt);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/fakeram45_64x96_req_ctrl.sv
// Request/response initiator for the fakeram45 64x96 macro, zero-filling the array after reset.
// Define FAKERAM_REQ_CTRL_RSP_BYPASS_EN to return read data combinationally when the FIFO is empty.
module fakeram45_64x96_req_ctrl
    import fakeram_req_ctrl_pkg::*;
#(
    parameter int unsigned BITS       = DefBits,
    parameter int unsigned WORD_DEPTH = DefWordDepth,
    parameter int unsigned ADDR_WIDTH = DefAddrWidth,
    parameter int unsigned RSP_DEPTH  = DefRspDepth
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  init_done_out,
    input  logic                  req_valid_in,
    output logic                  req_ready_out,
    input  logic                  req_we_in,
    input  logic [ADDR_WIDTH-1:0] req_addr_in,
    input  logic [BITS-1:0]       req_wdata_in,
    input  logic [BITS-1:0]       req_wmask_in,
    output logic                  rsp_valid_out,
    input  logic                  rsp_ready_in,
    output logic [BITS-1:0]       rsp_data_out,
    output logic                  sram_ce_out,
    output logic                  sram_we_out,
    output logic [ADDR_WIDTH-1:0] sram_addr_out,
    output logic [BITS-1:0]       sram_wd_out,
    output logic [BITS-1:0]       sram_w_mask_out,
    input  logic [BITS-1:0]       sram_rd_in
);

    localparam int unsigned           CntW        = cnt_width(RSP_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LastAddr    = ADDR_WIDTH'(WORD_DEPTH - 1);
    localparam logic [CntW:0]         CreditLimit = (CntW + 1)'(RSP_DEPTH);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] init_addr_q, init_addr_d;
    logic                  rd_pending_q, rd_pending_d;

    logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CntW-1:0]       fifo_count;
    logic [BITS-1:0]       fifo_rdata;
    logic [CntW:0]         credits_used;
    logic                  accept;

    assign credits_used  = {1'b0, fifo_count} + {{CntW{1'b0}}, rd_pending_q};
    assign fifo_pop      = ~fifo_empty & rsp_ready_in;
    assign init_done_out = (state_q == RUN);

`ifdef FAKERAM_REQ_CTRL_RSP_BYPASS_EN
    // An empty FIFO lets the macro word go straight out; it is only stored if not taken.
    assign rsp_valid_out = ~fifo_empty | rd_pending_q;
    assign rsp_data_out  = fifo_empty ? sram_rd_in : fifo_rdata;
    assign fifo_push     = rd_pending_q & ~(fifo_empty & rsp_ready_in);
`else
    assign rsp_valid_out = ~fifo_empty;
    assign rsp_data_out  = fifo_rdata;
    assign fifo_push     = rd_pending_q;
`endif

    always_comb begin
        state_d         = state_q;
        init_addr_d     = init_addr_q;
        rd_pending_d    = 1'b0;
        req_ready_out   = 1'b0;
        accept          = 1'b0;
        sram_ce_out     = 1'b0;
        sram_we_out     = 1'b0;
        sram_addr_out   = '0;
        sram_wd_out     = '0;
        sram_w_mask_out = '0;
        unique case (state_q)
            INIT: begin
                // Gated by rst_n so the macro stays idle while reset is held.
                sram_ce_out     = rst_n;
                sram_we_out     = rst_n;
                sram_addr_out   = init_addr_q;
                sram_w_mask_out = {BITS{rst_n}};
                init_addr_d     = init_addr_q + 1'b1;
                if (init_addr_q == LastAddr) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                req_ready_out = (credits_used < CreditLimit) | fifo_pop;
                accept        = req_valid_in & req_ready_out;
                sram_ce_out   = accept;
                sram_we_out   = accept & req_we_in;
                rd_pending_d  = accept & ~req_we_in;
                if (accept) begin
                    sram_addr_out = req_addr_in;
                end
                if (accept && req_we_in) begin
                    sram_wd_out     = req_wdata_in;
                    sram_w_mask_out = req_wmask_in;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= INIT;
            init_addr_q  <= '0;
            rd_pending_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            init_addr_q  <= init_addr_d;
            rd_pending_q <= rd_pending_d;
        end
    end

    // Credit accounting must keep every push absorbable.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(fifo_push && fifo_full && !fifo_pop));
        end
    end

    fakeram_rsp_fifo #(
        .Width (BITS),
        .Depth (RSP_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (fifo_push),
        .wdata_i (sram_rd_in),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

endmodule

// File: tb/tb_fakeram45_64x96_req_ctrl.sv
// Randomised bench for fakeram45_64x96_req_ctrl with an in-bench macro and a queue-based reference.
module tb_fakeram45_64x96_req_ctrl;

    localparam int BITS = 96;
    localparam int WD   = 64;
    localparam int AW   = 6;
    localparam int RD   = 2;
`ifdef FAKERAM_REQ_CTRL_RSP_BYPASS_EN
    localparam int LAT  = 1;
`else
    localparam int LAT  = 2;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            init_done, req_valid, req_ready, req_we, rsp_valid, rsp_ready;
    logic [AW-1:0]   req_addr, sram_addr;
    logic [BITS-1:0] req_wdata, req_wmask, rsp_data, sram_wd, sram_w_mask, sram_rd;
    logic            sram_ce, sram_we;

    always #5 clk = ~clk;

    fakeram45_64x96_req_ctrl u_dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .init_done_out   (init_done),
        .req_valid_in    (req_valid),
        .req_ready_out   (req_ready),
        .req_we_in       (req_we),
        .req_addr_in     (req_addr),
        .req_wdata_in    (req_wdata),
        .req_wmask_in    (req_wmask),
        .rsp_valid_out   (rsp_valid),
        .rsp_ready_in    (rsp_ready),
        .rsp_data_out    (rsp_data),
        .sram_ce_out     (sram_ce),
        .sram_we_out     (sram_we),
        .sram_addr_out   (sram_addr),
        .sram_wd_out     (sram_wd),
        .sram_w_mask_out (sram_w_mask),
        .sram_rd_in      (sram_rd)
    );

    // Macro stand-in: rd_out valid one cycle after a read, garbage otherwise.
    logic [BITS-1:0] macro_mem [WD];
    logic [BITS-1:0] macro_rd_q, junk_q;
    logic            macro_rd_vld_q = 1'b0;

    always @(posedge clk) begin
        junk_q         <= {$urandom(), $urandom(), $urandom()};
        macro_rd_vld_q <= sram_ce && !sram_we;
        if (sram_ce) begin
            if (sram_we) begin
                macro_mem[sram_addr] <= (macro_mem[sram_addr] & ~sram_w_mask) |
                                        (sram_wd & sram_w_mask);
            end else begin
                macro_rd_q <= macro_mem[sram_addr];
            end
        end
    end
    assign sram_rd = macro_rd_vld_q ? macro_rd_q : junk_q;

    // Reference: memory array plus queue of outstanding read results tagged by accept cycle.
    typedef struct {
        logic [BITS-1:0] data;
        int              acc;
    } rsp_t;

    rsp_t            exp_q[$];
    logic [BITS-1:0] ref_mem [WD];
    bit              in_run;
    int              init_k, cyc;
    int              n_tests, n_fail;
    int              n_acc, n_rsp, init_cycles;
    logic [BITS-1:0] last_rsp;

    task automatic chk(input string nm, input logic [BITS-1:0] act, input logic [BITS-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic reset_model();
        exp_q.delete();
        for (int i = 0; i < WD; i++) ref_mem[i] = '0;
        in_run = 1'b0;
        init_k = 0;
        cyc    = 0;
    endtask

    task automatic step(input bit v, input bit we, input logic [AW-1:0] a,
                        input logic [BITS-1:0] d, input logic [BITS-1:0] m, input bit rr);
        bit e_ready, e_acc, e_valid, e_fifo_pop, e_take;
        req_valid = v;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        req_wmask = m;
        rsp_ready = rr;
        e_acc     = 1'b0;
        e_take    = 1'b0;
        @(negedge clk);
        if (!rst_n) begin
            chk("rst_init_done", init_done, 0);
            chk("rst_req_ready", req_ready, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_ce", sram_ce, 0);
        end else if (!in_run) begin
            init_cycles++;
            chk("init_done_low", init_done, 0);
            chk("init_ready_low", req_ready, 0);
            chk("init_rsp_valid", rsp_valid, 0);
            chk("init_ce", sram_ce, 1);
            chk("init_we", sram_we, 1);
            chk("init_addr", sram_addr, init_k);
            chk("init_wd", sram_wd, '0);
            chk("init_mask", sram_w_mask, {BITS{1'b1}});
        end else begin
            e_valid    = (exp_q.size() > 0) && (cyc >= exp_q[0].acc + LAT);
            e_fifo_pop = e_valid && rr && (cyc >= exp_q[0].acc + 2);
            e_ready    = (exp_q.size() < RD) || e_fifo_pop;
            e_acc      = v && e_ready;
            e_take     = e_valid && rr;
            chk("init_done", init_done, 1);
            chk("req_ready", req_ready, e_ready);
            chk("sram_ce", sram_ce, e_acc);
            chk("sram_we", sram_we, e_acc && we);
            chk("sram_addr", sram_addr, e_acc ? a : '0);
            if (!e_acc) begin
                chk("idle_wd", sram_wd, '0);
                chk("idle_mask", sram_w_mask, '0);
            end else if (we) begin
                chk("wr_wd", sram_wd, d);
                chk("wr_mask", sram_w_mask, m);
            end
            chk("rsp_valid", rsp_valid, e_valid);
            if (e_valid) chk("rsp_data", rsp_data, exp_q[0].data);
            chk("push_into_full",
                u_dut.u_fifo.push_i && u_dut.u_fifo.full_o && !u_dut.u_fifo.pop_i, 0);
        end
        @(posedge clk);
        if (rst_n) begin
            if (!in_run) begin
                init_k++;
                if (init_k == WD) in_run = 1'b1;
            end else begin
                if (e_take) begin
                    last_rsp = exp_q[0].data;
                    n_rsp++;
                    void'(exp_q.pop_front());
                end
                if (e_acc) begin
                    n_acc++;
                    if (we) ref_mem[a] = (ref_mem[a] & ~m) | (d & m);
                    else exp_q.push_back('{ref_mem[a], cyc});
                end
                cyc++;
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, '0, 1'b1);
    endtask

    task automatic hold_reset();
        rst_n = 1'b0;
        reset_model();
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, '0, '0, '0, 1'b1);
        rst_n       = 1'b1;
        init_cycles = 0;
    endtask

    logic [BITS-1:0] ones, pat_a5, pat_t3;

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        ones     = '1;
        pat_a5   = {12{8'hA5}};
        pat_t3   = {{88{1'b1}}, 8'h00};
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_wmask = '0;
        rsp_ready = 1'b1;

        // Reset values and zero-fill length.
        hold_reset();
        idle(WD + 4);
        chk("init_len", init_cycles, 64);

        // A read after init returns zero.
        last_rsp = ones;
        step(1'b1, 1'b0, 6'd3, '0, '0, 1'b1);
        idle(3);
        chk("t1_zero", last_rsp, '0);

        // Write then read-back on the next cycle.
        last_rsp = '0;
        step(1'b1, 1'b1, 6'd5, pat_a5, ones, 1'b1);
        step(1'b1, 1'b0, 6'd5, '0, '0, 1'b1);
        idle(3);
        chk("t2_a5", last_rsp, pat_a5);

        // Partial mask preserves unmasked bits.
        step(1'b1, 1'b1, 6'd9, ones, ones, 1'b1);
        step(1'b1, 1'b1, 6'd9, '0, {{88{1'b0}}, 8'hFF}, 1'b1);
        step(1'b1, 1'b0, 6'd9, '0, '0, 1'b1);
        idle(3);
        chk("t3_mask", last_rsp, pat_t3);

        // Backpressure: only RSP_DEPTH reads accepted, then drained in order.
        for (int i = 1; i <= 4; i++) step(1'b1, 1'b1, AW'(i), BITS'(i), ones, 1'b1);
        idle(3);
        n_acc = 0;
        for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, AW'(i), '0, '0, 1'b0);
        chk("t4_accepts", n_acc, RD);
        n_rsp = 0;
        idle(5);
        chk("t4_rsp_count", n_rsp, RD);
        chk("t4_last", last_rsp, 2);

        // Streaming reads with a ready consumer: one accept per cycle.
        n_acc = 0;
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, AW'(i), '0, '0, 1'b1);
        chk("t5_accepts", n_acc, 10);
        idle(4);

        // Random traffic on a small address window to force collisions.
        for (int i = 0; i < 600; i++) begin
            logic [BITS-1:0] m;
            m = ($urandom_range(0, 1) == 0) ? ones : {$urandom(), $urandom(), $urandom()};
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)),
                 {$urandom(), $urandom(), $urandom()}, m, $urandom_range(0, 3) != 0);
        end
        idle(6);

        // Reset part-way through init, at address 30.
        hold_reset();
        idle(30);
        chk("t6_at_addr30", init_k, 30);
        hold_reset();
        idle(WD + 2);
        chk("t6_init_len", init_cycles, 64);

        // Reset with one read pending.
        step(1'b1, 1'b1, 6'd7, ones, ones, 1'b1);
        step(1'b1, 1'b0, 6'd7, '0, '0, 1'b1);
        hold_reset();
        idle(WD + 4);
        chk("t6b_init_len", init_cycles, 64);
        last_rsp = '0;
        step(1'b1, 1'b0, 6'd7, '0, '0, 1'b1);
        idle(3);
        chk("t6b_zero_after_reinit", last_rsp, '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
